barrel_shift: RTL and testbench

//  Single-clock, parameterised N-bit barrel shifter with registered output. Performs

---
 rtl/barrel_shift_pkg.sv | 50 +++++
 rtl/barrel_shift_if.sv | 10 +
 rtl/barrel_shift_stage.sv | 30 +++
 rtl/barrel_shift.sv | 107 ++++++++++
 tb/tb_barrel_shift.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/barrel_shift_pkg.sv
// Shared types and helpers for the barrel shifter: operation codes, fill modes,
// and the bit reversal that maps left shifts/rotates onto the right-shift network.
package barrel_shift_pkg;

  localparam int MAX_N = 64;
  localparam int IDX_W = $clog2(MAX_N);

  typedef enum logic [2:0] {
    OP_LSR = 3'd0,
    OP_ASR = 3'd1,
    OP_LSL = 3'd2,
    OP_ROR = 3'd3,
    OP_ROL = 3'd4
  } shift_op_e;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_SIGN = 2'd1,
    FILL_WRAP = 2'd2
  } fill_e;

  function automatic fill_e fill_of(input logic [2:0] op);
    case (op)
      OP_ASR:  return FILL_SIGN;
      OP_ROR:  return FILL_WRAP;
      OP_ROL:  return FILL_WRAP;
      default: return FILL_ZERO;
    endcase
  endfunction

  function automatic logic is_reversed(input logic [2:0] op);
    return (op == OP_LSL) || (op == OP_ROL);
  endfunction

  function automatic logic is_shift(input logic [2:0] op);
    return op <= OP_ROL;
  endfunction

  // Reverses the low n bits of v; bits at and above n are returned as zero.
  function automatic logic [MAX_N-1:0] bit_reverse(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) r[IDX_W'(i)] = v[IDX_W'(n - 1 - i)];
      else       r[IDX_W'(i)] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shift_if.sv
// Operand/result bundle of the barrel shifter; the driver holds the master side.
interface barrel_shift_if #(parameter int N = 8);
  logic [N-1:0]         data_in;
  logic [$clog2(N)-1:0] shift_num;
  logic [2:0]           op;
  logic [N-1:0]         data_out;

  modport master (output data_in, output shift_num, output op, input data_out);
  modport slave  (input data_in, input shift_num, input op, output data_out);
endinterface

// File: rtl/barrel_shift_stage.sv
// One logarithmic right-shift stage: shifts by 2**K when sel_i is set, filling the
// vacated MSBs with zeros, copies of the sign bit, or the bits leaving the LSB end.
module barrel_shift_stage
  import barrel_shift_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 0
) (
  input  logic [N-1:0] data_i,
  input  logic         sel_i,
  input  fill_e        fill_i,
  output logic [N-1:0] data_o
);
  localparam int SH = 2 ** K;

  logic [SH-1:0] fill_s;

  always_comb begin
    case (fill_i)
      FILL_SIGN: fill_s = {SH{data_i[N-1]}};
      FILL_WRAP: fill_s = data_i[SH-1:0];
      default:   fill_s = '0;
    endcase
  end

  always_comb begin
    if (sel_i) data_o = {fill_s, data_i[N-1:SH]};
    else       data_o = data_i;
  end
endmodule

// File: rtl/barrel_shift.sv
// N-bit barrel shifter (LSR/ASR/LSL/ROR/ROL, pass-through for other ops) with a
// registered result. Define BARREL_SHIFT_PIPE_EN to register every mux stage.
module barrel_shift
  import barrel_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  barrel_shift_if.slave  bs
);
  localparam int LOG2 = $clog2(N);

  if (N < 2 || N > MAX_N || (N & (N - 1)) != 0) begin : g_bad_n
    $error("barrel_shift: N must be a power of two in 2..%0d", MAX_N);
  end

  logic [N-1:0]                 entry_data_s;
  logic [LOG2-1:0]              entry_amt_s;
  logic [LOG2-1:0][N-1:0]       stg_in_s;
  logic [LOG2-1:0][N-1:0]       stg_out_s;
  logic [LOG2-1:0][2:0]         stg_op_s;
  logic [LOG2-1:0][LOG2-1:0]    stg_amt_s;
  logic [N-1:0]                 exit_data_s;
  logic [2:0]                   exit_op_s;
  logic [N-1:0]                 data_d;
  logic [N-1:0]                 data_q;
  logic                         unused_s;

  // Left shifts/rotates run reversed through the right-shift network; other ops shift by zero.
  always_comb begin
    if (is_shift(bs.op)) entry_amt_s = bs.shift_num;
    else                 entry_amt_s = '0;
    if (is_reversed(bs.op)) entry_data_s = N'(bit_reverse(MAX_N'(bs.data_in), N));
    else                    entry_data_s = bs.data_in;
  end

`ifdef BARREL_SHIFT_PIPE_EN
  logic [LOG2-1:0][N-1:0]    pipe_data_q;
  logic [LOG2-1:0][2:0]      pipe_op_q;
  logic [LOG2-1:0][LOG2-1:0] pipe_amt_q;
`endif

  for (genvar k = 0; k < LOG2; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stg_in_s[k]  = entry_data_s;
      assign stg_op_s[k]  = bs.op;
      assign stg_amt_s[k] = entry_amt_s;
    end else begin : g_next
`ifdef BARREL_SHIFT_PIPE_EN
      assign stg_in_s[k]  = pipe_data_q[k-1];
      assign stg_op_s[k]  = pipe_op_q[k-1];
      assign stg_amt_s[k] = pipe_amt_q[k-1];
`else
      assign stg_in_s[k]  = stg_out_s[k-1];
      assign stg_op_s[k]  = bs.op;
      assign stg_amt_s[k] = entry_amt_s;
`endif
    end

    barrel_shift_stage #(.N(N), .K(k)) u_stage (
      .data_i (stg_in_s[k]),
      .sel_i  (stg_amt_s[k][k]),
      .fill_i (fill_of(stg_op_s[k])),
      .data_o (stg_out_s[k])
    );

`ifdef BARREL_SHIFT_PIPE_EN
    // Pipeline register after stage k; op and amount travel with the data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_data_q[k] <= '0;
        pipe_op_q[k]   <= '0;
        pipe_amt_q[k]  <= '0;
      end else begin
        pipe_data_q[k] <= stg_out_s[k];
        pipe_op_q[k]   <= stg_op_s[k];
        pipe_amt_q[k]  <= stg_amt_s[k];
      end
    end
`endif
  end

`ifdef BARREL_SHIFT_PIPE_EN
  assign exit_data_s = pipe_data_q[LOG2-1];
  assign exit_op_s   = pipe_op_q[LOG2-1];
  assign unused_s    = ^{stg_amt_s, pipe_amt_q[LOG2-1]};
`else
  assign exit_data_s = stg_out_s[LOG2-1];
  assign exit_op_s   = bs.op;
  assign unused_s    = ^stg_amt_s;
`endif

  // Undo the operand reversal for left shifts/rotates.
  always_comb begin
    if (is_reversed(exit_op_s)) data_d = N'(bit_reverse(MAX_N'(exit_data_s), N));
    else                        data_d = exit_data_s;
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign bs.data_out = data_q;
endmodule

// File: tb/tb_barrel_shift.sv
// Self-checking bench for barrel_shift: directed vector table, mid-stream reset,
// and a random run, all checked through a latency-aware scoreboard.
module tb_barrel_shift;
  localparam int N  = 8;
  localparam int SW = $clog2(N);
`ifdef BARREL_SHIFT_PIPE_EN
  localparam int LAT = SW + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  barrel_shift_if #(.N(N)) bs ();
  barrel_shift #(.N(N)) dut (.clk(clk), .rst(rst), .bs(bs));

  typedef struct {
    logic [N-1:0]  d;
    logic [SW-1:0] s;
    logic [2:0]    op;
    logic [N-1:0]  exp;
    string         name;
  } vec_t;

  typedef struct {
    logic [N-1:0] exp;
    int           due;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  vec_t vec[18];
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_model(input logic [N-1:0] d, input logic [SW-1:0] s,
                                             input logic [2:0] op);
    logic signed [N-1:0] sd;
    int sh;
    sd = d;
    sh = int'(s);
    case (op)
      3'd0:    return d >> sh;
      3'd1:    return N'(sd >>> sh);
      3'd2:    return d << sh;
      3'd3:    return (sh == 0) ? d : ((d >> sh) | (d << (N - sh)));
      3'd4:    return (sh == 0) ? d : ((d << sh) | (d >> (N - sh)));
      default: return d;
    endcase
  endfunction

  task automatic apply(input logic [N-1:0] d, input logic [SW-1:0] s, input logic [2:0] op,
                       input logic [N-1:0] exp, input string name);
    @(negedge clk);
    bs.data_in   = d;
    bs.shift_num = s;
    bs.op        = op;
    sb_q.push_back('{exp, cycle + LAT, name});
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 4 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Scoreboard: compare the head entry when its cycle comes up.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      cycle++;
      if (!rst && sb_q.size() > 0 && sb_q[0].due <= cycle) begin
        e = sb_q.pop_front();
        check(e.name, bs.data_out, e.exp);
      end
    end
  end

  initial begin
    vec[0]  = '{8'h96, 3'd3, 3'd0, 8'h12, "lsr_s3"};
    vec[1]  = '{8'h96, 3'd3, 3'd1, 8'hF2, "asr_s3"};
    vec[2]  = '{8'h96, 3'd3, 3'd2, 8'hB0, "lsl_s3"};
    vec[3]  = '{8'h96, 3'd3, 3'd3, 8'hD2, "ror_s3"};
    vec[4]  = '{8'h96, 3'd3, 3'd4, 8'hB4, "rol_s3"};
    vec[5]  = '{8'h96, 3'd0, 3'd0, 8'h96, "lsr_s0"};
    vec[6]  = '{8'h96, 3'd0, 3'd1, 8'h96, "asr_s0"};
    vec[7]  = '{8'h96, 3'd0, 3'd2, 8'h96, "lsl_s0"};
    vec[8]  = '{8'h96, 3'd0, 3'd3, 8'h96, "ror_s0"};
    vec[9]  = '{8'h96, 3'd0, 3'd4, 8'h96, "rol_s0"};
    vec[10] = '{8'h96, 3'd5, 3'd5, 8'h96, "pass_op5"};
    vec[11] = '{8'h96, 3'd5, 3'd6, 8'h96, "pass_op6"};
    vec[12] = '{8'h96, 3'd5, 3'd7, 8'h96, "pass_op7"};
    vec[13] = '{8'h80, 3'd7, 3'd1, 8'hFF, "asr_max_neg"};
    vec[14] = '{8'h40, 3'd7, 3'd1, 8'h00, "asr_max_pos"};
    vec[15] = '{8'h80, 3'd7, 3'd0, 8'h01, "lsr_max"};
    vec[16] = '{8'h81, 3'd1, 3'd4, 8'h03, "rol_wrap"};
    vec[17] = '{8'h81, 3'd1, 3'd3, 8'hC0, "ror_wrap"};

    rst          = 1'b1;
    bs.data_in   = 8'h00;
    bs.shift_num = 3'd0;
    bs.op        = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", bs.data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, issued back to back.
    foreach (vec[i]) apply(vec[i].d, vec[i].s, vec[i].op, vec[i].exp, vec[i].name);
    drain();

    // Reset asserted between edges while a nonzero result is held.
    apply(8'h96, 3'd5, 3'd5, 8'h96, "pre_reset");
    drain();
    @(negedge clk);
    #2;
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("reset_async", bs.data_out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold", bs.data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release", bs.data_out, 8'h00);
    apply(8'h81, 3'd1, 3'd3, 8'hC0, "post_reset");
    drain();

    // Random stream against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0]  d;
      logic [SW-1:0] s;
      logic [2:0]    op;
      d  = N'($urandom);
      s  = SW'($urandom_range(0, N - 1));
      op = 3'($urandom_range(0, 7));
      apply(d, s, op, ref_model(d, s, op), "random");
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
